// File: rtl/bcd_count_pkg.sv
// rtl/bcd_count_pkg.sv - shared command codes, FSM states and BCD constants
//
// Shared by the BCD countdown timer and the BCD up-counter:
//   CMD_*   : encodings of the 2-bit controller command bus `state`
//   fsm_e   : countdown FSM states
//   BCD_W   : width of one BCD digit
//   BCD_MAX : largest legal BCD digit value
package bcd_count_pkg;

  localparam logic [1:0] CMD_HOLD0 = 2'd0;
  localparam logic [1:0] CMD_HOLD1 = 2'd1;
  localparam logic [1:0] CMD_LOAD  = 2'd2;
  localparam logic [1:0] CMD_RUN   = 2'd3;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    FSM_IDLE    = 2'd0,
    FSM_ARMED   = 2'd1,
    FSM_RUN     = 2'd2,
    FSM_EXPIRED = 2'd3
  } fsm_e;

endpackage

// File: rtl/bcd_digit_dec.sv
// rtl/bcd_digit_dec.sv - one BCD digit of a combinational decrement chain
//
// Ports:
//   digit_i  : current BCD digit (0..9)
//   borrow_i : borrow from the next-lower digit (1 = subtract one here)
//   digit_o  : resulting BCD digit
//   borrow_o : borrow passed to the next-higher digit
module bcd_digit_dec
  import bcd_count_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  input  logic             borrow_i,
  output logic [BCD_W-1:0] digit_o,
  output logic             borrow_o
);

  always_comb begin
    digit_o  = digit_i;
    borrow_o = 1'b0;
    if (borrow_i) begin
      if (digit_i == '0) begin
        digit_o  = BCD_MAX;
        borrow_o = 1'b1;
      end else begin
        digit_o  = digit_i - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_count_down.sv
// rtl/bcd_count_down.sv - loadable multi-digit BCD countdown timer
//
// Optional feature macro: BCD_COUNTDOWN_AUTORELOAD_EN (periodic auto-reload
// from EXPIRED; when undefined EXPIRED is terminal until the next load).
//
// Ports:
//   clock      : rising-edge clock
//   resetn     : asynchronous active-low reset
//   state      : controller command (0/1 hold, 2 load, 3 run)
//   tick       : count-enable strobe, honoured only with state == run
//   load_value : BCD preset, digit 0 in bits [3:0]; digits > 9 clamp to 9
//   count      : registered BCD count
//   zero       : count == 0
//   busy       : FSM is in RUN
//   done       : one-cycle pulse when the count expires
module bcd_count_down
  import bcd_count_pkg::*;
#(
  parameter int DIGITS = 5
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [1:0]              state,
  input  logic                    tick,
  input  logic [BCD_W*DIGITS-1:0] load_value,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    zero,
  output logic                    busy,
  output logic                    done
);

  localparam int W = BCD_W * DIGITS;

  fsm_e           fsm_q, fsm_d;
  logic [W-1:0]   count_q, count_d;
  logic           done_q, done_d;

  logic [W-1:0]   load_clamped;
  logic [W-1:0]   dec_src;
  logic [W-1:0]   dec_value;
  logic [DIGITS:0] borrow;
  logic           src_zero;
  logic           dec_zero;
  logic           advance;

  always_comb begin
    load_clamped = load_value;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_value[i*BCD_W +: BCD_W] > BCD_MAX) begin
        load_clamped[i*BCD_W +: BCD_W] = BCD_MAX;
      end
    end
  end

`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
  // A tick in EXPIRED reloads the preset and consumes that tick as the first
  // decrement, so the expiry period is exactly `preset` ticks.
  assign dec_src = (fsm_q == FSM_EXPIRED) ? load_clamped : count_q;
`else
  assign dec_src = count_q;
`endif

  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    bcd_digit_dec u_dec (
      .digit_i  (dec_src[g*BCD_W +: BCD_W]),
      .borrow_i (borrow[g]),
      .digit_o  (dec_value[g*BCD_W +: BCD_W]),
      .borrow_o (borrow[g+1])
    );
  end

  // The source is always valid BCD, so a borrow escaping the top digit
  // means every digit was 0: the source value itself is zero.
  assign src_zero = borrow[DIGITS];
  assign dec_zero = (dec_value == '0);

  always_comb begin
    fsm_d   = fsm_q;
    count_d = count_q;
    done_d  = 1'b0;
    advance = 1'b0;

    if (state == CMD_LOAD) begin
      count_d = load_clamped;
      fsm_d   = FSM_ARMED;
    end else if (state == CMD_RUN && tick) begin
      case (fsm_q)
        FSM_ARMED, FSM_RUN: advance = 1'b1;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
        FSM_EXPIRED:        advance = 1'b1;
`endif
        default:            advance = 1'b0;
      endcase

      if (advance) begin
        if (src_zero) begin
          count_d = '0;
          fsm_d   = FSM_EXPIRED;
          done_d  = 1'b1;
        end else begin
          count_d = dec_value;
          if (dec_zero) begin
            fsm_d  = FSM_EXPIRED;
            done_d = 1'b1;
          end else begin
            fsm_d  = FSM_RUN;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fsm_q   <= FSM_IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);
  assign busy  = (fsm_q == FSM_RUN);
  assign done  = done_q;

endmodule

// File: tb/tb_bcd_count_down.sv
// tb/tb_bcd_count_down.sv - randomized self-checking bench for bcd_count_down
module tb_bcd_count_down;

  logic        clock = 1'b0;
  logic        resetn;
  logic [1:0]  state;
  logic        tick;
  logic [19:0] load_value;
  logic [19:0] count;
  logic        zero;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_EXP = 3;
  int m_val;
  int m_fsm;
  bit m_done;
  int dones;

  bcd_count_down #(.DIGITS(5)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .state      (state),
    .tick       (tick),
    .load_value (load_value),
    .count      (count),
    .zero       (zero),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int x;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int clamp_dec(input logic [19:0] lv);
    int v, p, d;
    v = 0;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      d = int'(lv[i*4 +: 4]);
      if (d > 9) d = 9;
      v += d * p;
      p *= 10;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_val  = 0;
    m_fsm  = M_IDLE;
    m_done = 0;
  endtask

  task automatic model_step(input logic [1:0] st, input logic tk, input logic [19:0] lv);
    int v;
    m_done = 0;
    if (st == 2'd2) begin
      m_val = clamp_dec(lv);
      m_fsm = M_ARMED;
    end else if (st == 2'd3 && tk) begin
      if (m_fsm == M_ARMED || m_fsm == M_RUN) begin
        if (m_val == 0) begin
          m_fsm = M_EXP; m_done = 1;
        end else begin
          m_val = m_val - 1;
          if (m_val == 0) begin m_fsm = M_EXP; m_done = 1; end
          else m_fsm = M_RUN;
        end
      end else if (m_fsm == M_EXP) begin
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
        v = clamp_dec(lv);
        if (v > 0) v = v - 1;
        m_val = v;
        if (v == 0) begin m_fsm = M_EXP; m_done = 1; end
        else m_fsm = M_RUN;
`endif
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_count"}, 32'(count), 32'(to_bcd(m_val)));
    check({tag, "_zero"},  32'(zero),  32'(m_val == 0));
    check({tag, "_busy"},  32'(busy),  32'(m_fsm == M_RUN));
    check({tag, "_done"},  32'(done),  32'(m_done));
  endtask

  task automatic cycle(input logic [1:0] st, input logic tk, input logic [19:0] lv);
    @(negedge clock);
    state = st; tick = tk; load_value = lv;
    @(posedge clock);
    model_step(st, tk, lv);
    #1;
    check_outputs("cyc");
    if (done) dones++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_async");
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    logic [19:0] lv;
    int r;

    resetn = 1'b0; state = 2'd0; tick = 1'b0; load_value = '0;
    model_reset();
    #12;
    check("reset_count", 32'(count), 32'h0);
    check("reset_zero",  32'(zero),  32'h1);
    check("reset_busy",  32'(busy),  32'h0);
    check("reset_done",  32'(done),  32'h0);
    @(negedge clock);
    resetn = 1'b1;

    // 100 ticks from 00100
    cycle(2'd2, 1'b0, 20'h00100);
    dones = 0;
    repeat (100) cycle(2'd3, 1'b1, 20'h00100);
    check("t1_count", 32'(count), 32'h0);
    check("t1_done",  32'(done),  32'h1);
    check("t1_busy",  32'(busy),  32'h0);
    check("t1_ndone", 32'(dones), 32'd1);
    cycle(2'd0, 1'b0, 20'h00100);
    check("t1_done_drop", 32'(done), 32'h0);

    // full borrow chain
    cycle(2'd2, 1'b0, 20'h10000);
    cycle(2'd3, 1'b1, 20'h10000);
    check("t2_count", 32'(count), 32'h09999);
    check("t2_zero",  32'(zero),  32'h0);
    check("t2_busy",  32'(busy),  32'h1);

    // pause
    cycle(2'd2, 1'b0, 20'h00050);
    repeat (10) cycle(2'd3, 1'b1, 20'h00050);
    repeat (20) cycle(2'd1, 1'b1, 20'h00050);
    check("t3_paused", 32'(count), 32'h00040);
    repeat (5) cycle(2'd3, 1'b1, 20'h00050);
    check("t3_count", 32'(count), 32'h00035);

    // clamp and zero preset
    cycle(2'd2, 1'b0, 20'h000A5);
    check("t4_clamp", 32'(count), 32'h00095);
    cycle(2'd2, 1'b0, 20'h00000);
    cycle(2'd3, 1'b1, 20'h00000);
    check("t4_zdone",  32'(done),  32'h1);
    check("t4_zcount", 32'(count), 32'h0);

    // reset mid-run
    cycle(2'd2, 1'b0, 20'h00050);
    repeat (8) cycle(2'd3, 1'b1, 20'h00050);
    check("t5_pre", 32'(count), 32'h00042);
    do_reset();
    check("t5_count", 32'(count), 32'h0);
    check("t5_zero",  32'(zero),  32'h1);
    check("t5_busy",  32'(busy),  32'h0);
    dones = 0;
    repeat (5) cycle(2'd3, 1'b1, 20'h00050);
    check("t5_idle_count", 32'(count), 32'h0);
    check("t5_idle_ndone", 32'(dones), 32'd0);

    // expiry and optional auto-reload
    cycle(2'd2, 1'b0, 20'h00003);
    dones = 0;
    for (int i = 1; i <= 7; i++) begin
      cycle(2'd3, 1'b1, 20'h00003);
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
      check("t6_done", 32'(done), 32'(i == 3 || i == 6));
`else
      check("t6_done", 32'(done), 32'(i == 3));
`endif
    end
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
    check("t6_count", 32'(count), 32'h00002);
    check("t6_ndone", 32'(dones), 32'd2);
`else
    check("t6_count", 32'(count), 32'h00000);
    check("t6_ndone", 32'(dones), 32'd1);
`endif

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom % 250 == 0) begin
        do_reset();
      end else begin
        lv = 20'($urandom);
        if ($urandom % 4 != 0) lv[19:8] = '0;
        r = int'($urandom % 16);
        if (r == 0)      cycle(2'd2, 1'($urandom), lv);
        else if (r < 3)  cycle(2'(r - 1), 1'($urandom), lv);
        else             cycle(2'd3, 1'($urandom % 4 != 0), lv);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_count_down.md
# bcd_count_down

Loadable multi-digit BCD countdown timer; the down-counting counterpart to the team's BCD up-counter. It uses the same 2-bit `state` command bus from the top-level controller. It loads a BCD preset, decrements once per qualified `tick` with digit-wise borrow, and signals expiry with a one-cycle `done` pulse. It drives the seven-segment display path and the controller's timeout input.

## Interface
- `DIGITS`, 5: number of BCD digits; count width is 4*DIGITS.
- `clock`  in  1  rising-edge system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `state`  in  2  controller command: 0/1 = hold, 2 = load, 3 = run.
- `tick`  in  1  count-enable strobe, one clock wide; honoured only when `state`==3.
- `load_value`  in  4*DIGITS  BCD preset, digit 0 in bits [3:0].
- `count`  out  4*DIGITS  current BCD value (registered).
- `zero`  out  1  high when `count` equals 0.
- `busy`  out  1  high while the FSM is in RUN.
- `done`  out  1  one-cycle pulse when the count expires.

## Operation
- FSM states:
  - IDLE: after reset.
  - ARMED: loaded, not yet ticked.
  - RUN: counting.
  - EXPIRED: reached zero.
- Command priority, highest first: reset, then `state`==2, then `state`==3 with `tick`, then hold.
- `state`==2, from any FSM state:
  - `count` <= `load_value`, with each digit >9 clamped to 9.
  - FSM -> ARMED; `done` = 0.
  - `tick` is ignored that cycle.
- `state`==3 and `tick`, in ARMED or RUN:
  - If `count` != 0: decrement. Digit 0 subtracts 1; any digit at 0 that receives a borrow becomes 9 and passes the borrow upward. FSM -> RUN.
  - If the decrement result is 0: FSM -> EXPIRED, and `done` pulses on the same edge that writes 0.
  - If `count` is already 0 (a zero preset): no arithmetic. FSM -> EXPIRED and `done` pulses.
- `state`==3 and `tick` in EXPIRED: behaviour is set by the configuration macro.
- `state`==3 and `tick` in IDLE: ignored; the count is never armed.
- `state` 0 or 1: `count` and FSM hold and `tick` is ignored (pause). Returning to 3 resumes from the held value.
- `state`==3 with `tick` low: hold.
- Underflow is impossible: arithmetic never runs on a zero count.
- Output decodes:
  - `zero` is decoded from the `count` register.
  - `busy` = (FSM == RUN).

## Timing
- Reset values: `count` = 0, `zero` = 1, `busy` = 0, `done` = 0, FSM = IDLE.
- Reset is asynchronous assert, synchronous release. Asserting it mid-run forces the reset values immediately; no `done` is generated.
- Latency is one clock from a sampled `tick` or load to the updated `count`, `zero`, `busy` and `done`.
- `done` is high for exactly one cycle per expiry, including back-to-back expiries.
- A full borrow chain resolves in a single cycle; there is no multi-cycle ripple.
- `tick` held high for N cycles produces N decrements.

## Configuration
- `BCD_COUNTDOWN_AUTORELOAD_EN` defined:
  - In EXPIRED, `state`==3 with `tick` reloads the clamped `load_value`. FSM -> RUN, or EXPIRED with another `done` pulse if the preset is 0.
  - This gives a periodic timer with period = preset ticks.
- Macro undefined:
  - EXPIRED is terminal until the next `state`==2.
  - `count` stays 0 and further ticks produce no `done`.

## Structure
- Shared package `bcd_count_pkg` holds:
  - The `state` command constants: CMD_HOLD0=0, CMD_HOLD1=1, CMD_LOAD=2, CMD_RUN=3.
  - The FSM enum.
  - BCD_MAX=9 and the BCD digit width.
  - The up-counter will adopt the same command constants.
- One sub-module, `bcd_digit_dec`:
  - Inputs: a 4-bit digit and borrow-in.
  - Outputs: the next digit and borrow-out.
  - Instantiated DIGITS times in a generate chain, with the digit 0 borrow-in = 1 when decrementing.
- The load-clamp logic lives in the top module.

## Test plan
- Load 00100 (`state`=2), then `state`=3 with `tick` every cycle for 100 cycles -> `count` = 00000 after the 100th tick, `done` high for that one cycle only, `busy` low, FSM in EXPIRED.
- Load 10000, one tick -> `count` = 09999 (full borrow chain in one cycle), `zero` = 0, `busy` = 1.
- Load 00050, 10 ticks, `state`=1 with 20 ticks, `state`=3 with 5 ticks -> `count` = 00035; no change during the pause.
- Load 0x000A5 (invalid digit) -> `count` = 00095; load 00000 with one tick -> `done` pulse, `count` = 00000.
- `resetn` low mid-run at count 00042 -> `count` = 0, `zero` = 1, `busy` = 0 immediately. After release, ticks with `state`=3 leave `count` at 0 and no `done` until a load.
- Load 00003, 7 ticks:
  - With the macro: `done` pulses on ticks 3 and 6, and `count` = 00002 after tick 7.
  - Without it: a single `done` on tick 3, then `count` stays 00000.
